uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver, successor to the fixed 8N1 RX. Adds runtime parity
//  and stop-bit selection, 3-sample majority voting, false-start rejection,
//  framing/parity error flags and a ready/valid output buffer with overrun detect.
//  Sits between the pad-level rx_line and the byte-stream consumer (FIFO / core).
// PARAMETERS
//  CLK_FREQ  50000000  system clock in Hz; baud divisors derived from it
//  DATA_W    8         data bits per frame, legal 5..9, LSB received first
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  rx_line     in   1       asynchronous serial input, idle high
//  mode        in   4       baud: 0=4800 1=9600 2=115200 3=256000 other=9600
//  parity_mode in   2       0=none 1=even 2=odd 3=none
//  stop_bits   in   1       0=one stop bit, 1=two stop bits
//  data        out  DATA_W  received word, valid while data_valid=1, else 0
//  data_valid  out  1       word available; held until accepted
//  data_ready  in   1       consumer accepts when data_valid&&data_ready
//  frame_err   out  1       stop bit(s) sampled low; qualified by data_valid
//  parity_err  out  1       parity mismatch; qualified by data_valid
//  overrun     out  1       sticky: a frame was dropped because buffer was full
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, sync flops=1, counters=0. Reset mid-frame
//    aborts the frame; nothing is delivered.
//  - rx_line passes a 3-flop synchronizer; bit value = majority of last 3 synced
//    samples (s[2:0]) at the sample instant.
//  - Divisor BIT = round(CLK_FREQ/baud) = (CLK_FREQ+baud/2)/baud; at 50 MHz:
//    10417, 5208, 434, 195. HALF = BIT>>1. mode, parity_mode, stop_bits are
//    latched on start detection; changes mid-frame have no effect.
//  - FSM:
//    IDLE: synced falling edge (prev=1, cur=0) -> START, cnt=1.
//    START: cnt counts up; at cnt==HALF sample: 0 -> DATA, cnt=0; 1 -> IDLE
//      (glitch, no output, no flags).
//    DATA: at cnt==BIT sample, shift right into data_r, cnt=0, bit_cnt++;
//      after DATA_W bits -> PARITY if enabled, else STOP.
//    PARITY: at cnt==BIT sample p; perr = (^data_r ^ p) != odd_sel -> STOP.
//    STOP: at cnt==BIT sample; 0 sets ferr. If stop_bits=1 repeat once (STOP2).
//      After final stop sample -> DELIVER (1 cycle) -> IDLE; a low final stop bit
//      still returns to IDLE, and a new start edge is accepted only after the line
//      is seen high again.
//    DELIVER: if !data_valid or (data_valid && data_ready) this cycle: load
//      data/frame_err/parity_err, data_valid=1. Else drop frame, set overrun.
//  - Latency: data_valid rises 2 cycles after the centre of the final stop bit.
//  - Handshake: data_valid deasserts the cycle after accept unless DELIVER
//    reloads in that same cycle (then stays 1 with new word). overrun clears on
//    the next accepted transfer; simultaneous accept+overrun-set -> overrun=1.
//  - Counter width = $clog2(max BIT+1); no wrap within a frame.
// STRUCTURE
//  - uart_pkg: rx_state_t enum (IDLE,START,DATA,PARITY,STOP,STOP2,DELIVER),
//    parity_t enum, baud_div(clk_freq, mode) function, CNT_W constant.
//  - Sub-module rx_sync_vote: 3-flop synchronizer + majority vote + falling-edge
//    strobe; outputs bit_val, fall.
// TESTING  (CLK_FREQ=50e6, mode=2, BIT=434, DATA_W=8)
//  1) 8N1 byte 0xA5, data_ready=1 -> data=0xA5, valid 1 cycle, no errors,
//     ~9.5*434 cycles after start edge.
//  2) parity_mode=1, send 0x5A with parity bit 1 -> data=0x5A, parity_err=1;
//     same byte with parity 0 -> parity_err=0.
//  3) stop bit driven low -> frame_err=1, data delivered; next frame is clean.
//  4) 100-cycle low glitch on idle line -> no data_valid, FSM back in IDLE.
//  5) data_ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun=1;
//     assert ready -> accept, overrun=0.
//  6) rst pulse at bit 4 of a frame -> outputs 0, next full frame 0x3C received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and baud helpers for the configurable UART receiver.
// Divisors are rounded to the nearest clock count.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      STOP2,
      DELIVER
   } rx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'd0,
      PAR_EVEN  = 2'd1,
      PAR_ODD   = 2'd2,
      PAR_NONE3 = 2'd3
   } parity_t;

   function automatic int unsigned baud_div(
      input int unsigned clk_freq,
      input logic [3:0]  mode
   );
      case (mode)
         4'd0:    return (clk_freq + 2400) / 4800;
         4'd1:    return (clk_freq + 4800) / 9600;
         4'd2:    return (clk_freq + 57600) / 115200;
         4'd3:    return (clk_freq + 128000) / 256000;
         default: return (clk_freq + 4800) / 9600;
      endcase
   endfunction

   // Slowest baud gives the largest divisor, so it sizes the counter
   function automatic int unsigned cnt_w(input int unsigned clk_freq);
      return $clog2(baud_div(clk_freq, 4'd0) + 1);
   endfunction

   localparam int unsigned CNT_W = cnt_w(50000000);

endpackage

// File: rtl/rx_sync_vote.sv
// Synchronizer, 3-sample majority vote and falling-edge strobe
// for the asynchronous serial input.
module rx_sync_vote (
   input  logic clk,
   input  logic rst,
   input  logic rx_line,
   output logic bit_val,
   output logic fall
);

   logic [2:0] s_q;
   logic       prev_q;

   assign bit_val = (s_q[0] & s_q[1]) |
                    (s_q[1] & s_q[2]) |
                    (s_q[0] & s_q[2]);

   assign fall = prev_q & ~bit_val;

   // Shift in the line and remember the last voted level
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= 3'b111;
         prev_q <= 1'b1;
      end else begin
         s_q    <= {s_q[1:0], rx_line};
         prev_q <= bit_val;
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime baud/parity/stop selection,
// error flags and a one-word ready/valid buffer with overrun flag.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned DATA_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_line,
   input  logic [3:0]        mode,
   input  logic [1:0]        parity_mode,
   input  logic              stop_bits,
   output logic [DATA_W-1:0] data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              frame_err,
   output logic              parity_err,
   output logic              overrun
);

   localparam int unsigned CW = cnt_w(CLK_FREQ);

   logic bit_val;
   logic fall;

   rx_sync_vote u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx_line (rx_line),
      .bit_val (bit_val),
      .fall    (fall)
   );

   rx_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        bcnt_q, bcnt_d;
   logic [DATA_W-1:0] shr_q, shr_d;
   logic [3:0]        mode_q, mode_d;
   parity_t           par_q, par_d;
   logic              stop2_q, stop2_d;
   logic              ferr_q, ferr_d;
   logic              perr_q, perr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              dv_q, dv_d;
   logic              fe_q, fe_d;
   logic              pe_q, pe_d;
   logic              ovr_q, ovr_d;

   logic [CW-1:0] bit_lim;
   logic [CW-1:0] half_lim;
   logic          par_en;
   logic          odd_sel;
   logic          at_bit;
   logic          accept;

   assign bit_lim  = CW'(baud_div(CLK_FREQ, mode_q));
   assign half_lim = bit_lim >> 1;
   assign par_en   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
   assign odd_sel  = (par_q == PAR_ODD);
   assign at_bit   = (cnt_q == bit_lim);
   assign accept   = dv_q & data_ready;

   assign data       = data_q;
   assign data_valid = dv_q;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;
   assign overrun    = ovr_q;

   // Frame FSM, bit timing and output buffer next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bcnt_d  = bcnt_q;
      shr_d   = shr_q;
      mode_d  = mode_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      data_d  = data_q;
      dv_d    = dv_q;
      fe_d    = fe_q;
      pe_d    = pe_q;
      ovr_d   = ovr_q;

      if (accept) begin
         dv_d   = 1'b0;
         data_d = '0;
         fe_d   = 1'b0;
         pe_d   = 1'b0;
         ovr_d  = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_d   = CW'(1);
               bcnt_d  = 4'd0;
               mode_d  = mode;
               par_d   = parity_t'(parity_mode);
               stop2_d = stop_bits;
               ferr_d  = 1'b0;
               perr_d  = 1'b0;
            end
         end
         START: begin
            if (cnt_q == half_lim) begin
               cnt_d   = '0;
               state_d = bit_val ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (at_bit) begin
               shr_d  = {bit_val, shr_q[DATA_W-1:1]};
               cnt_d  = '0;
               bcnt_d = bcnt_q + 4'd1;
               if (bcnt_q == 4'(DATA_W - 1)) begin
                  state_d = par_en ? PARITY : STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PARITY: begin
            if (at_bit) begin
               perr_d  = ((^shr_q) ^ bit_val) != odd_sel;
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            if (at_bit) begin
               if (!bit_val) ferr_d = 1'b1;
               cnt_d   = '0;
               state_d = stop2_q ? STOP2 : DELIVER;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP2: begin
            if (at_bit) begin
               if (!bit_val) ferr_d = 1'b1;
               cnt_d   = '0;
               state_d = DELIVER;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DELIVER: begin
            state_d = IDLE;
            if (!dv_q || accept) begin
               data_d = shr_q;
               fe_d   = ferr_q;
               pe_d   = perr_q;
               dv_d   = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and buffer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bcnt_q  <= '0;
         shr_q   <= '0;
         mode_q  <= '0;
         par_q   <= PAR_NONE;
         stop2_q <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bcnt_q  <= bcnt_d;
         shr_q   <= shr_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         fe_q    <= fe_d;
         pe_q    <= pe_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at 115200 baud (434 clocks/bit),
// 8 data bits, 50 MHz clock.
module tb_uart_rx_cfg;

   localparam int BITC = 434;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line = 1'b1;
   logic [3:0] mode = 4'd2;
   logic [1:0] parity_mode = 2'd0;
   logic       stop_bits = 1'b0;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready = 1'b1;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;

   int nvec = 0;
   int nerr = 0;

   int cyc = 0;
   int vcnt = 0;
   int rise_cyc = 0;
   logic       dv_prev = 1'b0;
   logic [7:0] last_d = 8'h00;
   logic       last_fe = 1'b0;
   logic       last_pe = 1'b0;

   uart_rx_cfg #(
      .CLK_FREQ (50000000),
      .DATA_W   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_line     (rx_line),
      .mode        (mode),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .data        (data),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun     (overrun)
   );

   always #10 clk = ~clk;

   // Record every cycle the output buffer holds a word
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (data_valid) begin
         vcnt    = vcnt + 1;
         last_d  = data;
         last_fe = frame_err;
         last_pe = parity_err;
         if (!dv_prev) rise_cyc = cyc;
      end
      dv_prev = data_valid;
   end

   task automatic chk(input string tag, input int unsigned got,
                      input int unsigned exp);
      nvec = nvec + 1;
      if (got !== exp) begin
         nerr = nerr + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // pb < 0 means no parity bit on the wire
   task automatic send(input logic [7:0] b, input int pb,
                       input logic stopv);
      rx_line = 1'b0;
      wait_n(BITC);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         wait_n(BITC);
      end
      if (pb >= 0) begin
         rx_line = pb[0];
         wait_n(BITC);
      end
      rx_line = stopv;
      wait_n(BITC);
      rx_line = 1'b1;
      wait_n(300);
   endtask

   int v0;
   int e0;

   initial begin
      wait_n(5);
      chk("rst_data", data, 8'h00);
      chk("rst_valid", data_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ovr", overrun, 0);
      rst = 1'b0;
      wait_n(20);

      // 8N1 0xA5, consumer always ready
      v0 = vcnt;
      e0 = cyc;
      send(8'hA5, -1, 1'b1);
      chk("t1_cnt", vcnt - v0, 1);
      chk("t1_data", last_d, 8'hA5);
      chk("t1_ferr", last_fe, 0);
      chk("t1_perr", last_pe, 0);
      chk("t1_lat", ((rise_cyc - e0) >= 4100) && ((rise_cyc - e0) <= 4160), 1);
      chk("t1_idle_data", data, 8'h00);

      // Even parity, wrong then right parity bit
      parity_mode = 2'd1;
      v0 = vcnt;
      send(8'h5A, 1, 1'b1);
      chk("t2a_cnt", vcnt - v0, 1);
      chk("t2a_data", last_d, 8'h5A);
      chk("t2a_perr", last_pe, 1);
      v0 = vcnt;
      send(8'h5A, 0, 1'b1);
      chk("t2b_cnt", vcnt - v0, 1);
      chk("t2b_perr", last_pe, 0);
      parity_mode = 2'd0;

      // Low stop bit, then a clean frame
      v0 = vcnt;
      send(8'hC3, -1, 1'b0);
      chk("t3a_cnt", vcnt - v0, 1);
      chk("t3a_data", last_d, 8'hC3);
      chk("t3a_ferr", last_fe, 1);
      v0 = vcnt;
      send(8'h96, -1, 1'b1);
      chk("t3b_data", last_d, 8'h96);
      chk("t3b_ferr", last_fe, 0);
      chk("t3b_cnt", vcnt - v0, 1);

      // Short low glitch on an idle line
      v0 = vcnt;
      rx_line = 1'b0;
      wait_n(100);
      rx_line = 1'b1;
      wait_n(600);
      chk("t4_novalid", vcnt - v0, 0);
      send(8'h81, -1, 1'b1);
      chk("t4_after", last_d, 8'h81);
      chk("t4_after_cnt", vcnt - v0, 1);

      // Overrun with a stalled consumer
      data_ready = 1'b0;
      send(8'h11, -1, 1'b1);
      chk("t5_valid1", data_valid, 1);
      chk("t5_data1", data, 8'h11);
      chk("t5_ovr1", overrun, 0);
      send(8'h22, -1, 1'b1);
      chk("t5_valid2", data_valid, 1);
      chk("t5_data2", data, 8'h11);
      chk("t5_ovr2", overrun, 1);
      data_ready = 1'b1;
      wait_n(1);
      chk("t5_acc_valid", data_valid, 0);
      chk("t5_acc_ovr", overrun, 0);
      chk("t5_acc_data", data, 8'h00);

      // Reset mid-frame while a word is pending
      data_ready = 1'b0;
      send(8'h77, -1, 1'b1);
      chk("t6_pend", data_valid, 1);
      rx_line = 1'b0;
      wait_n(BITC);
      for (int i = 0; i < 4; i++) begin
         rx_line = i[0];
         wait_n(BITC);
      end
      rx_line = 1'b1;
      wait_n(200);
      rst = 1'b1;
      wait_n(3);
      rst = 1'b0;
      wait_n(1);
      chk("t6_valid", data_valid, 0);
      chk("t6_data", data, 8'h00);
      chk("t6_ovr", overrun, 0);
      data_ready = 1'b1;
      v0 = vcnt;
      wait_n(5000);
      chk("t6_nothing", vcnt - v0, 0);
      send(8'h3C, -1, 1'b1);
      chk("t6_data2", last_d, 8'h3C);
      chk("t6_cnt2", vcnt - v0, 1);
      chk("t6_ferr2", last_fe, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
